// File: rtl/edge_x_sched.sv
// edge_x_sched: frame-periodic scheduler that opens a capture window at the
// start of every PERIOD_FRAMES-frame period, averages 2**LOG2_CAP valid
// edge_x samples (floor-truncated mean) and presents the result on a
// valid/ready port. Flags short periods and overwritten results.
module edge_x_sched #(
    parameter int X_W           = 12,
    parameter int LOG2_CAP      = 1,
    parameter int PERIOD_FRAMES = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           frame_sync,
    input  logic [X_W-1:0] edge_x,
    input  logic           edge_valid,
    output logic [X_W-1:0] res_data,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           busy,
    output logic           short_pulse,
    output logic           overrun
);

    localparam int CAP = 1 << LOG2_CAP;
    localparam int AW  = X_W + LOG2_CAP;
    localparam int NW  = LOG2_CAP + 1;
    localparam int FW  = $clog2(PERIOD_FRAMES);

    localparam logic [FW-1:0] LAST_FRAME = FW'(PERIOD_FRAMES - 1);
    localparam logic [NW-1:0] CAP_N      = NW'(CAP);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] HOLDOFF = 2'd2;

    logic          s0;
    logic          s1;
    logic          fs_rise;
    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] frame_cnt_next;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_next;
    logic [NW-1:0] n;
    logic [NW-1:0] n_next;
    logic          boundary;
    logic [AW-1:0] sum;
    logic [NW-1:0] cnt;
    logic          load_result;
    logic          short_next;

    // One-cycle pulse on each synchronised frame_sync rising edge.
    assign fs_rise  = s0 & ~s1;
    assign boundary = (frame_cnt == LAST_FRAME);

    // Two-flop synchroniser for the frame sync level; runs regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= frame_sync;
            s1 <= s0;
        end
    end

    // Next-state logic: period counting, sample accumulation, result trigger.
    // The boundary frame restarts the accumulator and is itself the first
    // capture opportunity, so sampling uses a zero base on that frame.
    always_comb begin
        state_next     = state;
        frame_cnt_next = frame_cnt;
        acc_next       = acc;
        n_next         = n;
        sum            = '0;
        cnt            = '0;
        load_result    = 1'b0;
        short_next     = 1'b0;
        if (!en) begin
            state_next     = IDLE;
            frame_cnt_next = LAST_FRAME;
            acc_next       = '0;
            n_next         = '0;
        end else if (fs_rise) begin
            if (boundary) begin
                frame_cnt_next = '0;
                short_next     = (state == CAPTURE);
                state_next     = CAPTURE;
                acc_next       = '0;
                n_next         = '0;
            end else begin
                frame_cnt_next = frame_cnt + FW'(1);
            end
            if ((boundary || state == CAPTURE) && edge_valid) begin
                sum = (boundary ? '0 : acc) + {{LOG2_CAP{1'b0}}, edge_x};
                cnt = (boundary ? '0 : n) + NW'(1);
                if (cnt == CAP_N) begin
                    load_result = 1'b1;
                    state_next  = HOLDOFF;
                    acc_next    = '0;
                    n_next      = '0;
                end else begin
                    state_next  = CAPTURE;
                    acc_next    = sum;
                    n_next      = cnt;
                end
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            frame_cnt   <= LAST_FRAME;
            acc         <= '0;
            n           <= '0;
            busy        <= 1'b0;
            short_pulse <= 1'b0;
        end else begin
            state       <= state_next;
            frame_cnt   <= frame_cnt_next;
            acc         <= acc_next;
            n           <= n_next;
            busy        <= (state_next == CAPTURE);
            short_pulse <= short_next;
        end
    end

    // Result port: load new mean, clear on handshake, flag overwrites.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data  <= '0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (load_result) begin
            res_data  <= sum[AW-1:LOG2_CAP];
            res_valid <= 1'b1;
            overrun   <= res_valid & ~res_ready;
        end else begin
            overrun <= 1'b0;
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_x_sched.sv
// Scoreboard bench for edge_x_sched: stimulus pushes expected means into a
// queue, a monitor pops and compares on every accepted result.
module tb_edge_x_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        frame_sync = 1'b0;
    logic [11:0] edge_x = '0;
    logic        edge_valid = 1'b0;
    logic [11:0] res_data;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        busy;
    logic        short_pulse;
    logic        overrun;

    int checks = 0;
    int failures = 0;
    int sp_cnt = 0;
    int ov_cnt = 0;
    int exp_q[$];

    edge_x_sched #(.X_W(12), .LOG2_CAP(1), .PERIOD_FRAMES(10)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .frame_sync(frame_sync),
        .edge_x(edge_x), .edge_valid(edge_valid), .res_data(res_data),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
        .short_pulse(short_pulse), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    // Monitor: compare every accepted result against the scoreboard and
    // count single-cycle flag pulses.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (res_valid && res_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result got=%0d required=none", res_data);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (res_data !== 12'(e)) begin
                        failures++;
                        $display("FAIL result got=%0d required=%0d", res_data, e);
                    end else begin
                        $display("ok   result = %0d", res_data);
                    end
                end
            end
            if (short_pulse) sp_cnt++;
            if (overrun) ov_cnt++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; frame_sync = 1'b0; edge_valid = 1'b0;
        edge_x = '0; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_res_valid", {31'd0, res_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        sp_cnt = 0;
        ov_cnt = 0;
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic frame(input logic [11:0] x, input logic v, input int hi);
        @(negedge clk);
        edge_x = x; edge_valid = v; frame_sync = 1'b1;
        repeat (hi) @(negedge clk);
        frame_sync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // 1. basic average with latency check
        do_reset();
        frame(12'd100, 1'b1, 3);
        chk("t1_busy_after_f1", {31'd0, busy}, 1);
        exp_q.push_back(150);
        @(negedge clk);
        edge_x = 12'd200; edge_valid = 1'b1; frame_sync = 1'b1;
        @(negedge clk);
        chk("t1_lat_fs_cycle", {31'd0, res_valid}, 0);
        @(negedge clk);
        chk("t1_lat_plus1", {31'd0, res_valid}, 1);
        chk("t1_data", {20'd0, res_data}, 150);
        @(negedge clk);
        chk("t1_consumed", {31'd0, res_valid}, 0);
        frame_sync = 1'b0;
        repeat (4) @(negedge clk);
        for (int f = 3; f <= 10; f++) frame(12'd7, 1'b1, 3);
        chk("t1_busy_holdoff", {31'd0, busy}, 0);
        frame(12'd0, 1'b0, 3);
        chk("t1_busy_f11", {31'd0, busy}, 1);

        // 2. truncation and full-scale width
        do_reset();
        exp_q.push_back(101);
        frame(12'd101, 1'b1, 3);
        frame(12'd102, 1'b1, 3);
        for (int f = 3; f <= 10; f++) frame(12'd9, 1'b0, 3);
        exp_q.push_back(4095);
        frame(12'd4095, 1'b1, 3);
        frame(12'd4095, 1'b1, 3);
        chk("t2_no_short", sp_cnt, 0);

        // 3. skipped frame is never accumulated
        do_reset();
        exp_q.push_back(20);
        frame(12'd999, 1'b0, 3);
        frame(12'd10, 1'b1, 3);
        frame(12'd30, 1'b1, 3);

        // 4. short period
        do_reset();
        for (int f = 1; f <= 10; f++) frame(12'd5, 1'b0, 3);
        chk("t4_no_short_yet", sp_cnt, 0);
        frame(12'd5, 1'b0, 3);
        chk("t4_short_once", sp_cnt, 1);
        chk("t4_busy", {31'd0, busy}, 1);
        chk("t4_res_valid", {31'd0, res_valid}, 0);

        // 5. overrun while consumer stalls
        do_reset();
        res_ready = 1'b0;
        frame(12'd100, 1'b1, 3);
        frame(12'd200, 1'b1, 3);
        chk("t5_first_data", {20'd0, res_data}, 150);
        for (int f = 3; f <= 10; f++) frame(12'd1, 1'b0, 3);
        exp_q.push_back(300);
        frame(12'd250, 1'b1, 3);
        frame(12'd350, 1'b1, 3);
        chk("t5_overrun_once", ov_cnt, 1);
        chk("t5_data", {20'd0, res_data}, 300);
        chk("t5_valid", {31'd0, res_valid}, 1);
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        @(negedge clk);
        chk("t5_valid_cleared", {31'd0, res_valid}, 0);
        res_ready = 1'b1;

        // 6a. asynchronous reset mid-capture
        do_reset();
        frame(12'd500, 1'b1, 3);
        chk("t6a_busy_before", {31'd0, busy}, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6a_busy_async", {31'd0, busy}, 0);
        chk("t6a_valid_async", {31'd0, res_valid}, 0);
        chk("t6a_data_async", {20'd0, res_data}, 0);
        chk("t6a_flags_async", {30'd0, short_pulse, overrun}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(30);
        frame(12'd20, 1'b1, 3);
        frame(12'd40, 1'b1, 3);

        // 6b. enable drop mid-capture
        do_reset();
        frame(12'd500, 1'b1, 3);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6b_busy_disabled", {31'd0, busy}, 0);
        en = 1'b1;
        exp_q.push_back(30);
        frame(12'd20, 1'b1, 3);
        frame(12'd40, 1'b1, 3);
        chk("t6b_no_short", sp_cnt, 0);

        // 6c. long frame_sync high counts as a single frame
        do_reset();
        exp_q.push_back(70);
        frame(12'd60, 1'b1, 50);
        chk("t6c_no_result_yet", {31'd0, res_valid}, 0);
        frame(12'd80, 1'b1, 3);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
